// File: rtl/run_ctrl.sv
// run_ctrl: run/halt/single-step controller for the single-cycle core.
// Produces the commit enable (cpu_en) that gates the PC update and the
// register-file write, plus a PC breakpoint, a HALT-instruction trap and a
// retired-instruction counter.
//
// Handshake: a host command transfers on a rising clk edge where
// cmd_valid & cmd_ready are both 1. cmd_ready depends only on the current
// state, never on cmd_valid, so the host may hold cmd_valid/cmd_op stable
// until it sees the transfer. Commands are taken in HALTED and RUN only.
module run_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstd,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic [31:0]      pc,
  input  logic [31:0]      ins,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  output logic             cpu_en,
  output logic             halted,
  output logic [1:0]       stop_cause,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_HALTED = 2'd1,
    S_RUN    = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

  localparam logic [1:0] CAUSE_HOST = 2'b01;
  localparam logic [1:0] CAUSE_BP   = 2'b10;
  localparam logic [1:0] CAUSE_INS  = 2'b11;

  localparam logic [7:0]       HOLD_INIT = 8'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             resume_q, resume_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q;

  logic is_halt_ins;
  logic bp_hit;
  logic accept;
  logic unused_ins;

  // Only the opcode field matters for trap detection.
  assign is_halt_ins = (ins[31:26] == 6'b111111);
  assign unused_ins  = ^ins[25:0];
  // The resume flag masks the breakpoint for the first RUN cycle so the core
  // can restart from the breakpoint address.
  assign bp_hit      = bp_en && (pc == bp_addr) && !resume_q;
  assign cmd_ready   = (state_q == S_HALTED) || (state_q == S_RUN);
  assign accept      = cmd_valid && cmd_ready;

  // State, hold counter, resume flag and stop cause registers.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q  <= S_HOLD;
      hold_q   <= HOLD_INIT;
      resume_q <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      resume_q <= resume_d;
      cause_q  <= cause_d;
    end
  end

  // Next-state and commit-enable decode; stop checks use the current pc/ins
  // so a stopping instruction is never committed.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    resume_d = resume_q;
    cause_d  = cause_q;
    cpu_en   = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (hold_q <= 8'd1) state_d = S_HALTED;
        else                hold_d  = hold_q - 8'd1;
      end
      S_HALTED: begin
        if (accept) begin
          if (cmd_op == OP_RUN) begin
            state_d  = S_RUN;
            resume_d = 1'b1;
          end else if (cmd_op == OP_STEP) begin
            state_d = S_STEP;
          end
        end
      end
      S_RUN: begin
        resume_d = 1'b0;
        if (is_halt_ins) begin
          state_d = S_HALTED;
          cause_d = CAUSE_INS;
        end else if (bp_hit) begin
          state_d = S_HALTED;
          cause_d = CAUSE_BP;
        end else if (accept && (cmd_op == OP_HALT)) begin
          state_d = S_HALTED;
          cause_d = CAUSE_HOST;
        end else begin
          cpu_en = 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_HALTED;
        if (is_halt_ins) begin
          cause_d = CAUSE_INS;
        end else begin
          cpu_en  = 1'b1;
          cause_d = CAUSE_HOST;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  // Retired-instruction counter; wraps naturally, cleared only by reset.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd)       retired_q <= '0;
    else if (cpu_en) retired_q <= retired_q + CNT_ONE;
  end

  assign halted     = (state_q == S_HOLD) || (state_q == S_HALTED);
  assign stop_cause = cause_q;
  assign retired    = retired_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl. A tiny core stand-in advances pc
// by one per committed instruction; ins is a HALT opcode at halt_pc.
module tb_run_ctrl;

  localparam int CNT_W = 4;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

  logic             clk;
  logic             rstd;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic             cmd_ready;
  logic [31:0]      pc;
  logic [31:0]      ins;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic             cpu_en;
  logic             halted;
  logic [1:0]       stop_cause;
  logic [CNT_W-1:0] retired;
  logic [1:0]       state_dbg;
  logic [31:0]      halt_pc;

  int checks;
  int errors;

  run_ctrl #(.HOLD_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstd(rstd), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .pc(pc), .ins(ins), .bp_en(bp_en),
    .bp_addr(bp_addr), .cpu_en(cpu_en), .halted(halted),
    .stop_cause(stop_cause), .retired(retired), .state_dbg(state_dbg)
  );

  // Clock and core stand-in.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rstd) begin
    if (!rstd)       pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd1;
  end

  always_comb begin
    ins = (pc == halt_pc) ? 32'hFC00_0000 : (32'h0000_0013 | (pc << 7));
  end

  // Drive one command at a negedge; it must be ready before the edge.
  task automatic send_cmd(input logic [1:0] op, input string name);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s cmd_ready got %b want 1", name, cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  // Wait (bounded) for halted after a RUN.
  task automatic wait_halted(input string name);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s halted timeout got %b want 1", name, halted);
    end
  endtask

  // Release reset at a negedge with RUN pending; ready must rise on edge 4.
  task automatic release_and_hold(input string name);
    @(negedge clk);
    rstd      = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_RUN;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (cmd_ready !== (i == 4)) begin
        errors++;
        $display("FAIL %s cmd_ready edge %0d got %b want %b", name, i, cmd_ready, (i == 4));
      end
    end
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    checks++;
    if (halted !== 1'b1 || cpu_en !== 1'b0 || state_dbg !== 2'd1) begin
      errors++;
      $display("FAIL %s after_hold halted %b cpu_en %b state %0d want 1 0 1",
               name, halted, cpu_en, state_dbg);
    end
  endtask

  task automatic test_reset();
    rstd = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP;
    bp_en = 1'b0; bp_addr = 32'd0; halt_pc = 32'd5;
    #12;
    checks++;
    if (cpu_en !== 1'b0 || cmd_ready !== 1'b0 || halted !== 1'b1 ||
        stop_cause !== 2'b00 || retired !== 4'd0) begin
      errors++;
      $display("FAIL reset_values got cpu_en %b ready %b halted %b cause %b retired %0d want 0 0 1 00 0",
               cpu_en, cmd_ready, halted, stop_cause, retired);
    end
    release_and_hold("reset_hold");
  endtask

  // Breakpoint at 3, then resume through it to the HALT instruction at 5.
  task automatic test_bp_and_halt_ins();
    bp_en = 1'b1; bp_addr = 32'd3;
    send_cmd(OP_RUN, "bp_run1");
    wait_halted("bp_run1");
    checks++;
    if (pc !== 32'd3 || stop_cause !== 2'b10 || retired !== 4'd3 || cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_stop got pc %0d cause %b retired %0d cpu_en %b want 3 10 3 0",
               pc, stop_cause, retired, cpu_en);
    end
    send_cmd(OP_RUN, "bp_run2");
    checks++;
    if (pc !== 32'd3 || cpu_en !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL bp_resume got pc %0d cpu_en %b halted %b want 3 1 0", pc, cpu_en, halted);
    end
    wait_halted("halt_ins");
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'd5 || stop_cause !== 2'b11 || retired !== 4'd5 || cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL halt_ins got pc %0d cause %b retired %0d cpu_en %b want 5 11 5 0",
               pc, stop_cause, retired, cpu_en);
    end
  endtask

  // Step onto a HALT instruction (no commit), then three real steps.
  task automatic test_step();
    send_cmd(OP_STEP, "step_halt");
    checks++;
    if (halted !== 1'b0 || cmd_ready !== 1'b0 || cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL step_state got halted %b ready %b cpu_en %b want 0 0 0", halted, cmd_ready, cpu_en);
    end
    @(posedge clk);
    #1;
    checks++;
    if (halted !== 1'b1 || retired !== 4'd5 || pc !== 32'd5 || stop_cause !== 2'b11) begin
      errors++;
      $display("FAIL step_halt got halted %b retired %0d pc %0d cause %b want 1 5 5 11",
               halted, retired, pc, stop_cause);
    end
    halt_pc = 32'd100;
    for (int k = 1; k <= 3; k++) begin
      send_cmd(OP_STEP, "step");
      @(posedge clk);
      #1;
      checks++;
      if (retired !== 4'(5 + k) || pc !== 32'(5 + k) || stop_cause !== 2'b01 || halted !== 1'b1) begin
        errors++;
        $display("FAIL step_%0d got retired %0d pc %0d cause %b halted %b want %0d %0d 01 1",
                 k, retired, pc, stop_cause, halted, 5 + k, 5 + k);
      end
    end
  endtask

  // Host HALT mid-run, then HALT coinciding with a breakpoint.
  task automatic test_host_halt();
    bp_en = 1'b0;
    send_cmd(OP_RUN, "host_run");
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_HALT;
    #1;
    checks++;
    if (cpu_en !== 1'b0 || cmd_ready !== 1'b1 || pc !== 32'd11) begin
      errors++;
      $display("FAIL host_halt_cycle got cpu_en %b ready %b pc %0d want 0 1 11", cpu_en, cmd_ready, pc);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    checks++;
    if (halted !== 1'b1 || pc !== 32'd11 || retired !== 4'd11 || stop_cause !== 2'b01) begin
      errors++;
      $display("FAIL host_halt got halted %b pc %0d retired %0d cause %b want 1 11 11 01",
               halted, pc, retired, stop_cause);
    end
    bp_en = 1'b1; bp_addr = 32'd13;
    send_cmd(OP_RUN, "bp_host_run");
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_HALT;
    #1;
    checks++;
    if (cpu_en !== 1'b0 || cmd_ready !== 1'b1 || pc !== 32'd13) begin
      errors++;
      $display("FAIL bp_host_cycle got cpu_en %b ready %b pc %0d want 0 1 13", cpu_en, cmd_ready, pc);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    checks++;
    if (halted !== 1'b1 || retired !== 4'd13 || stop_cause !== 2'b10) begin
      errors++;
      $display("FAIL bp_host got halted %b retired %0d cause %b want 1 13 10", halted, retired, stop_cause);
    end
  endtask

  // Counter wrap 15 -> 0, then asynchronous reset between edges.
  task automatic test_wrap_and_reset();
    bp_en = 1'b0;
    send_cmd(OP_RUN, "wrap_run");
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (retired !== 4'd15) begin
      errors++;
      $display("FAIL wrap_pre got %0d want 15", retired);
    end
    @(posedge clk);
    #1;
    checks++;
    if (retired !== 4'd0) begin
      errors++;
      $display("FAIL wrap got %0d want 0", retired);
    end
    @(posedge clk);
    #3;
    checks++;
    if (cpu_en !== 1'b1 || retired !== 4'd1) begin
      errors++;
      $display("FAIL pre_reset got cpu_en %b retired %0d want 1 1", cpu_en, retired);
    end
    rstd = 1'b0;
    #1;
    checks++;
    if (cpu_en !== 1'b0 || retired !== 4'd0 || halted !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got cpu_en %b retired %0d halted %b ready %b want 0 0 1 0",
               cpu_en, retired, halted, cmd_ready);
    end
    release_and_hold("rehold");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bp_and_halt_ins();
    test_step();
    test_host_halt();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run/halt/single-step controller for the single-cycle RISC core. Sits between a host (debug/boot) command port and the core's commit path: it produces one commit enable that gates the PC register update in writeback and the register-file write. While it is deasserted the fetched instruction is held and no architectural state changes. It also provides a PC breakpoint, a HALT-instruction trap and a retired-instruction counter.

## Interface
- HOLD_CYCLES, 4: cycles held after reset release before the first command is accepted (1..255).
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  clock, rising edge.
- rstd  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  host command valid.
- cmd_op  in  2  00 NOP, 01 RUN, 10 HALT, 11 STEP.
- cmd_ready  out  1  command accepted on a rising edge when cmd_valid & cmd_ready.
- pc  in  32  current PC from writeback.
- ins  in  32  instruction fetched at pc.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  32  breakpoint PC.
- cpu_en  out  1  commit enable to the PC register and register-file write (combinational).
- halted  out  1  core is not running (HOLD or HALTED).
- stop_cause  out  2  00 reset, 01 host HALT/step done, 10 breakpoint, 11 HALT instruction.
- retired  out  CNT_W  count of committed instructions.

## Operation
- States: HOLD, HALTED, RUN, STEP.
- Reset: state HOLD, hold counter = HOLD_CYCLES, cpu_en 0, cmd_ready 0, halted 1, stop_cause 00, retired 0, resume flag 0.
- HOLD: cmd_ready 0, cpu_en 0. The hold counter decrements each cycle. When it reaches 1, the state moves to HALTED on the next edge.
- HALTED: cmd_ready 1, cpu_en 0.
  - RUN accepted: go to RUN and set the resume flag.
  - STEP accepted: go to STEP.
  - HALT or NOP accepted: no state change, and stop_cause is unchanged.
- HALT instruction: ins[31:26] == 6'b111111.
- RUN: cmd_ready 1. Stop conditions are evaluated on the current pc/ins before commit, in this priority order:
  1. HALT instruction: cpu_en 0, go to HALTED, stop_cause 11.
  2. Breakpoint (bp_en & pc == bp_addr & resume flag clear): cpu_en 0, go to HALTED, stop_cause 10.
  3. Host HALT accepted this cycle: cpu_en 0, go to HALTED, stop_cause 01.
  4. Otherwise: cpu_en 1.
- RUN, other cases:
  - RUN, STEP or NOP commands are accepted and ignored.
  - The resume flag clears after the first RUN cycle. This lets the core resume from the breakpoint address without re-breaking.
- STEP: cmd_ready 0.
  - If ins is a HALT instruction: cpu_en 0, stop_cause 11.
  - Otherwise: cpu_en 1, stop_cause 01.
  - Go to HALTED next edge in both cases. Breakpoints are ignored in STEP.
- retired increments by 1 at every rising edge where cpu_en = 1. It wraps modulo 2^CNT_W and is never cleared except by rstd.
- halted = 1 in HOLD and HALTED, 0 in RUN and STEP.

## Timing
- Command handshake is sampled at the rising edge. A command accepted at edge N takes effect from cycle N+1, so cpu_en first rises in cycle N+1 for RUN or STEP.
- cpu_en is combinational from state, pc, ins, bp_en/bp_addr and cmd_valid/cmd_op. The core's PC and register writes gated by it commit at the end of the same cycle.
- Stop latency is 0 cycles: the instruction at the stop point is never committed. halted rises at the following edge.
- STEP commits exactly one instruction, so retired increases by exactly 1 (0 if the instruction is a HALT).
- A host HALT arriving in the same cycle as a breakpoint or HALT instruction is still accepted (cmd_ready 1). stop_cause reflects the higher-priority cause.
- Reset assertion mid-RUN forces HOLD immediately and asynchronously: cpu_en drops without waiting for a clock, and retired is cleared.
- After reset release: HOLD lasts exactly HOLD_CYCLES cycles, then cmd_ready rises.

## Test plan
- Reset with HOLD_CYCLES=4: outputs at reset values. cmd_ready rises exactly 4 clocks after rstd release. A RUN issued during HOLD is not accepted.
- RUN on a program whose 6th instruction has opcode 111111: cpu_en drops at that PC, halted=1, stop_cause=11, retired=5, and PC is held at the HALT address.
- bp_en=1, bp_addr=0x3, RUN from 0:
  - stops with pc=3, stop_cause=10, retired=3.
  - A second RUN commits PC 3 without re-breaking and continues.
- From HALTED, three STEP commands: retired increments 1 per step, PC advances one instruction each, and stop_cause=01 after each.
- Host HALT asserted mid-run at cycle N: the instruction in cycle N is not committed and stop_cause=01. HALT together with a breakpoint hit in the same cycle gives stop_cause=10.
- rstd pulled low mid-RUN between clock edges: cpu_en=0 immediately and retired=0. After release, HOLD is re-entered, and the counter rolls from all-ones to 0 under forced CNT_W=4.
